// File: rtl/cpu_pkg.sv
// Shared types and field positions for the 8-bit CPU control sequencer.
// Optional build macro: CPU_SINGLE_STEP_EN adds the PAUSE state to ctrl_state_e.
package cpu_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int INSTR_W    = 16;
  localparam int IMM_W      = 8;

  // Instruction word field positions
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  // Opcodes A..E are unassigned and behave as NOP.
  typedef enum logic [3:0] {
    OPC_NOP  = 4'h0,
    OPC_ADD  = 4'h1,
    OPC_SUB  = 4'h2,
    OPC_AND  = 4'h3,
    OPC_OR   = 4'h4,
    OPC_XOR  = 4'h5,
    OPC_LDI  = 4'h6,
    OPC_MOV  = 4'h7,
    OPC_JMP  = 4'h8,
    OPC_JZ   = 4'h9,
    OPC_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_AND    = 3'd2,
    ALU_OR     = 3'd3,
    ALU_XOR    = 3'd4,
    ALU_PASS_B = 3'd5
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_WRITEBACK = 3'd3,
`ifdef CPU_SINGLE_STEP_EN
    ST_HALT      = 3'd4,
    ST_PAUSE     = 3'd5
`else
    ST_HALT      = 3'd4
`endif
  } ctrl_state_e;

  // Opcode field of an instruction word, as the enum type.
  function automatic opcode_e get_opcode(input logic [INSTR_W-1:0] iw);
    return opcode_e'(iw[OPC_MSB:OPC_LSB]);
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Purely combinational instruction decoder: IR -> register addresses,
// immediate, ALU control and instruction-class flags.
module instr_decoder
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [INSTR_W-1:0]    ir_i,
  output logic [REG_ADDR_W-1:0] rd_o,
  output logic [REG_ADDR_W-1:0] rs1_o,
  output logic [REG_ADDR_W-1:0] rs2_o,
  output logic [DATA_W-1:0]     imm_o,
  output alu_op_e               alu_op_o,
  output logic                  b_sel_o,
  output logic                  is_wb_o,
  output logic                  is_jmp_o,
  output logic                  is_jz_o,
  output logic                  is_halt_o
);

  logic [IMM_W-1:0] imm8;

  assign rd_o  = ir_i[RD_MSB:RD_LSB];
  assign rs1_o = ir_i[RS1_MSB:RS1_LSB];
  assign rs2_o = ir_i[RS2_MSB:RS2_LSB];
  assign imm8  = ir_i[IMM_MSB:IMM_LSB];

  // Map the opcode to ALU control and class flags; unlisted opcodes act as NOP.
  always_comb begin
    imm_o     = DATA_W'(imm8);
    alu_op_o  = ALU_ADD;
    b_sel_o   = 1'b0;
    is_wb_o   = 1'b0;
    is_jmp_o  = 1'b0;
    is_jz_o   = 1'b0;
    is_halt_o = 1'b0;
    case (get_opcode(ir_i))
      OPC_ADD: begin alu_op_o = ALU_ADD; is_wb_o = 1'b1; end
      OPC_SUB: begin alu_op_o = ALU_SUB; is_wb_o = 1'b1; end
      OPC_AND: begin alu_op_o = ALU_AND; is_wb_o = 1'b1; end
      OPC_OR:  begin alu_op_o = ALU_OR;  is_wb_o = 1'b1; end
      OPC_XOR: begin alu_op_o = ALU_XOR; is_wb_o = 1'b1; end
      OPC_LDI: begin
        alu_op_o = ALU_PASS_B;
        b_sel_o  = 1'b1;
        is_wb_o  = 1'b1;
      end
      // MOV is rs1 + 0: the rs2 field is ignored and a zero immediate is fed in.
      OPC_MOV: begin
        alu_op_o = ALU_ADD;
        b_sel_o  = 1'b1;
        imm_o    = '0;
        is_wb_o  = 1'b1;
      end
      OPC_JMP:  is_jmp_o  = 1'b1;
      OPC_JZ:   is_jz_o   = 1'b1;
      OPC_HALT: is_halt_o = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Multi-cycle control sequencer for the 8-bit CPU datapath.
// FETCH -> DECODE -> EXECUTE -> [WRITEBACK] -> FETCH, plus terminal HALT.
// Optional build macro: CPU_SINGLE_STEP_EN adds a `step` input and a PAUSE
// state entered instead of FETCH after every completed instruction.
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int PC_W   = 8,
  parameter int DATA_W = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [INSTR_W-1:0]    instr,
  input  logic                  instr_valid,
  input  logic                  alu_zero,
`ifdef CPU_SINGLE_STEP_EN
  input  logic                  step,
`endif
  output logic [PC_W-1:0]       pc,
  output logic [REG_ADDR_W-1:0] RA1,
  output logic [REG_ADDR_W-1:0] RA2,
  output logic [REG_ADDR_W-1:0] WA,
  output logic                  write_enable,
  output logic [2:0]            alu_op,
  output logic                  alu_b_sel,
  output logic [DATA_W-1:0]     imm,
  output logic                  halted
);

  // Where an instruction goes once it has finished.
`ifdef CPU_SINGLE_STEP_EN
  localparam ctrl_state_e DONE_ST = ST_PAUSE;
`else
  localparam ctrl_state_e DONE_ST = ST_FETCH;
`endif

  ctrl_state_e           state_q, state_d;
  logic [PC_W-1:0]       pc_q, pc_d;
  logic [INSTR_W-1:0]    ir_q, ir_d;
  logic                  z_q, z_d;
  logic [REG_ADDR_W-1:0] ra1_q, ra1_d;
  logic [REG_ADDR_W-1:0] ra2_q, ra2_d;
  logic [REG_ADDR_W-1:0] wa_q, wa_d;
  alu_op_e               alu_op_q, alu_op_d;
  logic                  b_sel_q, b_sel_d;
  logic [DATA_W-1:0]     imm_q, imm_d;

  logic [REG_ADDR_W-1:0] dec_rd, dec_rs1, dec_rs2;
  logic [DATA_W-1:0]     dec_imm;
  alu_op_e               dec_alu_op;
  logic                  dec_b_sel, dec_is_wb, dec_is_jmp, dec_is_jz, dec_is_halt;
  logic [PC_W-1:0]       pc_inc, pc_tgt;

  instr_decoder #(
    .DATA_W (DATA_W)
  ) u_decoder (
    .ir_i      (ir_q),
    .rd_o      (dec_rd),
    .rs1_o     (dec_rs1),
    .rs2_o     (dec_rs2),
    .imm_o     (dec_imm),
    .alu_op_o  (dec_alu_op),
    .b_sel_o   (dec_b_sel),
    .is_wb_o   (dec_is_wb),
    .is_jmp_o  (dec_is_jmp),
    .is_jz_o   (dec_is_jz),
    .is_halt_o (dec_is_halt)
  );

  // PC wraps naturally at 2^PC_W; branch target is the zero-extended imm8.
  assign pc_inc = pc_q + PC_W'(1);
  assign pc_tgt = PC_W'(ir_q[IMM_MSB:IMM_LSB]);

  // State, PC, IR, Z flag and registered datapath controls.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_FETCH;
      pc_q     <= '0;
      ir_q     <= '0;
      z_q      <= 1'b0;
      ra1_q    <= '0;
      ra2_q    <= '0;
      wa_q     <= '0;
      alu_op_q <= ALU_ADD;
      b_sel_q  <= 1'b0;
      imm_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      z_q      <= z_d;
      ra1_q    <= ra1_d;
      ra2_q    <= ra2_d;
      wa_q     <= wa_d;
      alu_op_q <= alu_op_d;
      b_sel_q  <= b_sel_d;
      imm_q    <= imm_d;
    end
  end

  // Next-state and sequencing decisions; everything holds unless a state changes it.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    z_d      = z_q;
    ra1_d    = ra1_q;
    ra2_d    = ra2_q;
    wa_d     = wa_q;
    alu_op_d = alu_op_q;
    b_sel_d  = b_sel_q;
    imm_d    = imm_q;
    case (state_q)
      ST_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = ST_DECODE;
        end
      end
      // Datapath controls are captured here and held through WRITEBACK.
      ST_DECODE: begin
        ra1_d    = dec_rs1;
        ra2_d    = dec_rs2;
        wa_d     = dec_rd;
        alu_op_d = dec_alu_op;
        b_sel_d  = dec_b_sel;
        imm_d    = dec_imm;
        state_d  = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        if (dec_is_halt) begin
          state_d = ST_HALT;
        end else if (dec_is_wb) begin
          state_d = ST_WRITEBACK;
        end else begin
          if (dec_is_jmp) begin
            pc_d = pc_tgt;
          end else if (dec_is_jz) begin
            pc_d = z_q ? pc_tgt : pc_inc;
          end else begin
            pc_d = pc_inc;
          end
          state_d = DONE_ST;
        end
      end
      ST_WRITEBACK: begin
        z_d     = alu_zero;
        pc_d    = pc_inc;
        state_d = DONE_ST;
      end
      ST_HALT: state_d = ST_HALT;
`ifdef CPU_SINGLE_STEP_EN
      ST_PAUSE: begin
        if (step) state_d = ST_FETCH;
      end
`endif
      default: state_d = ST_FETCH;
    endcase
  end

  // The register file samples write_enable on the same edge that applies RST,
  // so the strobe is masked by RST to drop a write caught mid-WRITEBACK.
  assign write_enable = (state_q == ST_WRITEBACK) && !RST;
  assign halted       = (state_q == ST_HALT);

  assign pc        = pc_q;
  assign RA1       = ra1_q;
  assign RA2       = ra2_q;
  assign WA        = wa_q;
  assign alu_op    = alu_op_q;
  assign alu_b_sel = b_sel_q;
  assign imm       = imm_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Self-checking bench for cpu_control_unit: a small register file + ALU
// environment around the DUT, and an instruction-level reference model.
module tb_cpu_control_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] instr;
  logic        instr_valid;
  logic        alu_zero;
  logic [7:0]  pc;
  logic [3:0]  RA1, RA2, WA;
  logic        write_enable;
  logic [2:0]  alu_op;
  logic        alu_b_sel;
  logic [7:0]  imm;
  logic        halted;
`ifdef CPU_SINGLE_STEP_EN
  logic        step;
`endif

  int checks = 0;
  int errors = 0;

  // Environment datapath
  logic [7:0] rf [16];
  logic [7:0] rf_seed [16];
  logic       rf_load;
  logic [7:0] alu_a, alu_b, alu_y;

  // Reference model state
  logic [7:0] m_rf [16];
  logic [7:0] m_pc;
  logic       m_z;

  cpu_control_unit #(.PC_W(8), .DATA_W(8)) dut (
`ifdef CPU_SINGLE_STEP_EN
    .step         (step),
`endif
    .CLK          (CLK),
    .RST          (RST),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .alu_zero     (alu_zero),
    .pc           (pc),
    .RA1          (RA1),
    .RA2          (RA2),
    .WA           (WA),
    .write_enable (write_enable),
    .alu_op       (alu_op),
    .alu_b_sel    (alu_b_sel),
    .imm          (imm),
    .halted       (halted)
  );

  always #5 CLK = ~CLK;

  function automatic logic [7:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return b;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    alu_a    = rf[RA1];
    alu_b    = alu_b_sel ? imm : rf[RA2];
    alu_y    = alu_ref(alu_op, alu_a, alu_b);
    alu_zero = (alu_y == 8'h00);
  end

  always @(posedge CLK) begin
    if (rf_load) rf <= rf_seed;
    else if (write_enable) rf[WA] <= alu_y;
  end

  task automatic test_reset();
    for (int i = 0; i < 16; i++) rf_seed[i] = 8'($urandom);
    m_rf = rf_seed;
    m_pc = 8'h00;
    m_z  = 1'b0;
    RST = 1'b1; rf_load = 1'b1; instr_valid = 1'b1; instr = 16'h6123;
`ifdef CPU_SINGLE_STEP_EN
    step = 1'b0;
`endif
    repeat (3) @(negedge CLK);
    rf_load = 1'b0;
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc got %h want 00", pc); end
    checks++; if ({RA1, RA2, WA} !== 12'h000) begin errors++; $display("FAIL reset_addr got %h want 000", {RA1, RA2, WA}); end
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL reset_we got %b want 0", write_enable); end
    checks++; if ({alu_op, alu_b_sel} !== 4'h0) begin errors++; $display("FAIL reset_alu got %h want 0", {alu_op, alu_b_sel}); end
    checks++; if (imm !== 8'h00) begin errors++; $display("FAIL reset_imm got %h want 00", imm); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
    RST = 1'b0;
    instr_valid = 1'b0;
    @(negedge CLK);
  endtask

  // Run one instruction from FETCH; `lows` cycles of instr_valid=0 precede the fetch.
  task automatic do_instr(input logic [15:0] iw, input int lows);
    logic [3:0] op, rd, rs1, rs2;
    logic [7:0] k, val, exp_imm;
    logic [2:0] exp_op;
    logic       wb, exp_bsel;
    op = iw[15:12]; rd = iw[11:8]; rs1 = iw[7:4]; rs2 = iw[3:0]; k = iw[7:0];
    val = 8'h00; exp_op = 3'd0; exp_bsel = 1'b0; exp_imm = k;
    wb = (op >= 4'd1 && op <= 4'd7);
    for (int i = 0; i < lows; i++) begin
      instr_valid = 1'b0; instr = 16'($urandom);
      checks++; if (pc !== m_pc || write_enable !== 1'b0) begin errors++; $display("FAIL fetch_wait pc %h we %b want pc %h we 0", pc, write_enable, m_pc); end
      @(negedge CLK);
    end
    instr_valid = 1'b1; instr = iw;
    checks++; if (pc !== m_pc) begin errors++; $display("FAIL fetch_pc got %h want %h", pc, m_pc); end
    @(negedge CLK);
    instr_valid = 1'($urandom); instr = 16'($urandom);
    checks++; if (write_enable !== 1'b0) begin errors++; $display("FAIL decode_we got %b want 0", write_enable); end
    @(negedge CLK);
    checks++; if (write_enable !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL execute_we we %b halted %b want 0 0", write_enable, halted); end
    if (op >= 4'd1 && op <= 4'd5) begin
      exp_op = 3'(op - 4'd1); val = alu_ref(exp_op, m_rf[rs1], m_rf[rs2]);
    end else if (op == 4'd6) begin
      exp_op = 3'd5; exp_bsel = 1'b1; val = k;
    end else if (op == 4'd7) begin
      exp_op = 3'd0; exp_bsel = 1'b1; exp_imm = 8'h00; val = m_rf[rs1];
    end
    if (op == 4'hF) begin
      for (int i = 0; i < 10; i++) begin
        @(negedge CLK);
        instr_valid = 1'b1; instr = 16'($urandom);
        checks++; if (halted !== 1'b1 || write_enable !== 1'b0 || pc !== m_pc) begin errors++; $display("FAIL halt halted %b we %b pc %h want 1 0 %h", halted, write_enable, pc, m_pc); end
      end
      return;
    end
    if (wb) begin
      @(negedge CLK);
      checks++; if (write_enable !== 1'b1) begin errors++; $display("FAIL wb_we got %b want 1", write_enable); end
      checks++; if (WA !== rd) begin errors++; $display("FAIL wb_wa got %h want %h", WA, rd); end
      checks++; if (alu_op !== exp_op || alu_b_sel !== exp_bsel) begin errors++; $display("FAIL wb_alu op %0d bsel %b want %0d %b", alu_op, alu_b_sel, exp_op, exp_bsel); end
      if (op >= 4'd6) begin
        checks++; if (imm !== exp_imm) begin errors++; $display("FAIL wb_imm got %h want %h", imm, exp_imm); end
      end
      if (op != 4'd6) begin
        checks++; if (RA1 !== rs1) begin errors++; $display("FAIL wb_ra1 got %h want %h", RA1, rs1); end
      end
      if (op <= 4'd5) begin
        checks++; if (RA2 !== rs2) begin errors++; $display("FAIL wb_ra2 got %h want %h", RA2, rs2); end
      end
      m_rf[rd] = val; m_z = (val == 8'h00); m_pc = m_pc + 8'd1;
    end else if (op == 4'd8) begin
      m_pc = k;
    end else if (op == 4'd9) begin
      m_pc = m_z ? k : m_pc + 8'd1;
    end else begin
      m_pc = m_pc + 8'd1;
    end
    @(negedge CLK);
    checks++; if (pc !== m_pc || write_enable !== 1'b0) begin errors++; $display("FAIL next_pc pc %h we %b want %h 0", pc, write_enable, m_pc); end
    if (wb) begin
      checks++; if (rf[rd] !== m_rf[rd]) begin errors++; $display("FAIL rf_write r%0d got %h want %h", rd, rf[rd], m_rf[rd]); end
    end
`ifdef CPU_SINGLE_STEP_EN
    step = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      checks++; if (pc !== m_pc || write_enable !== 1'b0) begin errors++; $display("FAIL pause pc %h we %b want %h 0", pc, write_enable, m_pc); end
    end
    step = 1'b1;
    @(negedge CLK);
    step = 1'b0;
`endif
  endtask

  task automatic test_ldi();
    do_instr(16'h6111, 0);
    checks++; if (rf[1] !== 8'h11 || pc !== 8'h01) begin errors++; $display("FAIL ldi r1 %h pc %h want 11 01", rf[1], pc); end
  endtask

  task automatic test_alu();
    do_instr(16'h6222, 0);
    do_instr(16'h1312, 0);
    checks++; if (rf[3] !== 8'h33) begin errors++; $display("FAIL add_r3 got %h want 33", rf[3]); end
  endtask

  task automatic test_jz();
    do_instr(16'h2411, 0);
    do_instr(16'h9040, 0);
    checks++; if (pc !== 8'h40) begin errors++; $display("FAIL jz_taken got %h want 40", pc); end
    do_instr(16'h6501, 0);
    do_instr(16'h9040, 0);
    checks++; if (pc !== 8'h42) begin errors++; $display("FAIL jz_not_taken got %h want 42", pc); end
  endtask

  task automatic test_fetch_stall();
    do_instr(16'h6677, 3);
    checks++; if (rf[6] !== 8'h77) begin errors++; $display("FAIL stall_r6 got %h want 77", rf[6]); end
  endtask

  task automatic test_wrap();
    do_instr(16'h80FF, 0);
    do_instr(16'h0000, 0);
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL pc_wrap got %h want 00", pc); end
  endtask

  task automatic test_random();
    logic [3:0] op;
    for (int n = 0; n < 60; n++) begin
      op = 4'($urandom_range(0, 14));
      do_instr({op, 12'($urandom)}, int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_reset_in_wb();
    instr_valid = 1'b1; instr = 16'h6FFF;
    @(negedge CLK);
    instr_valid = 1'b0;
    repeat (2) @(negedge CLK);
    checks++; if (write_enable !== 1'b1) begin errors++; $display("FAIL rstwb_we_before got %b want 1", write_enable); end
    RST = 1'b1;
    @(negedge CLK);
    checks++; if (write_enable !== 1'b0 || pc !== 8'h00) begin errors++; $display("FAIL rstwb_state we %b pc %h want 0 00", write_enable, pc); end
    checks++; if (rf[15] !== m_rf[15]) begin errors++; $display("FAIL rstwb_r15 got %h want %h", rf[15], m_rf[15]); end
    RST = 1'b0;
    m_pc = 8'h00; m_z = 1'b0;
    do_instr(16'h6A5A, 0);
  endtask

  task automatic test_halt();
    do_instr(16'hF000, 1);
  endtask

  initial begin
    test_reset();
    test_ldi();
    test_alu();
    test_jz();
    test_fetch_stall();
    test_wrap();
    test_reset_in_wb();
    test_random();
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
